pc_fetch_sequencer: RTL

Program-counter register and fetch sequencer for the RV32I datapath, sitting directly upstream of the PC+4 adder. It holds the architectural PC, drives it to the adder's A input and to instruction memory, and loads the next PC from either the adder result (PC+4) or a branch/jump target. It handles memory wait states, pipeline stalls and redirects that arrive mid-fetch, with optional misaligned-target trapping.

---
 rtl/pc_fetch_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Program-counter register and instruction-fetch sequencer for the RV32I
// datapath. It holds the architectural PC, drives it to the PC+4 adder and to
// instruction memory, and loads the next PC from either the adder result or a
// branch/jump target. It absorbs memory wait states and pipeline stalls. A
// redirect that arrives while no fetch is being accepted is parked and applied
// on the next accepted fetch.
//
// Build option:
//   PC_MISALIGN_TRAP_EN  When defined, a redirect target with bits [1:0] != 00
//                        is not loaded. The sequencer enters TRAP, raises
//                        MISALIGN and freezes until reset. When undefined, the
//                        low two bits of every target are cleared before
//                        loading, and misalign_o is tied low.
//
// Parameters:
//   RESET_VECTOR   PC loaded on reset (bits [1:0] must be 00)
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_n_i        synchronous active-low reset
//   pc_plus4_i     PC+4 from the adder (combinational from pc_o)
//   pc_target_i    branch/jump target
//   pc_src_i       1 = redirect to pc_target_i
//   stall_i        hold fetch; no request, no acceptance
//   imem_ready_i   memory accepts/returns the current request
//   pc_o           current PC (adder A input)
//   imem_req_o     fetch request valid
//   imem_addr_o    fetch address, always equal to pc_o
//   misalign_o     sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] pc_target_i,
    input  logic        pc_src_i,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        TRAP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        imem_req;
    logic        redirect;    // selected next PC comes from a target, not the adder
    logic [31:0] next_pc;

`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets its default value first. Any path that leaves
    // a variable unassigned would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_d    = misalign_q;
`endif
        imem_req      = 1'b0;
        redirect      = 1'b0;
        next_pc       = pc_plus4_i;

        case (state_q)
            BOOT: begin
                // One idle cycle after reset before the first request.
                state_d = FETCH;
            end

            FETCH: begin
                imem_req = !stall_i;
                if (imem_req && imem_ready_i) begin
                    // A live redirect beats a parked one, which beats PC+4.
                    if (pc_src_i) begin
                        next_pc  = pc_target_i;
                        redirect = 1'b1;
                    end else if (pend_valid_q) begin
                        next_pc  = pend_target_q;
                        redirect = 1'b1;
                    end
                    // The accepting fetch always consumes any parked redirect.
                    pend_valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                    if (redirect && (next_pc[1:0] != 2'b00)) begin
                        state_d    = TRAP;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
`else
                    // PC+4 from an aligned PC is already aligned. Only
                    // targets need their low bits cleared.
                    pc_d = redirect ? {next_pc[31:2], 2'b00} : next_pc;
`endif
                end else if (pc_src_i) begin
                    // Park the redirect. A newer one replaces an older one.
                    pend_valid_d  = 1'b1;
                    pend_target_d = pc_target_i;
                end
            end

            TRAP: begin
                // Frozen; only reset leaves this state.
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers (synchronous reset)
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments here, so every register samples the
    // values from before this edge regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;
    assign imem_req_o  = imem_req;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o  = misalign_q;
`else
    assign misalign_o  = 1'b0;
`endif

endmodule
